// File: rtl/flick_check_gen_if.sv
// Button/mode stimulus bus between the flick/check generator and the mode sequencer.
// The slave side (the generator) drives the check strobe, the flick level and the debounced button.
interface flick_check_gen_if;
    logic       btn_raw;
    logic [2:0] mode;
    logic       check;
    logic       flick;
    logic       btn_level;

    modport master (
        output btn_raw,
        output mode,
        input  check,
        input  flick,
        input  btn_level
    );

    modport slave (
        input  btn_raw,
        input  mode,
        output check,
        output flick,
        output btn_level
    );
endinterface

// File: rtl/flick_check_gen.sv
// Synchronises and debounces the push-button, classifies presses as flicks and
// generates the mode-dependent check strobe sampled by the mode sequencer.
module flick_check_gen #(
    parameter int DEB_CYCLES   = 4,
    parameter int FLICK_MAX    = 20,
    parameter int TICK_DIV     = 10,
    parameter int PERIOD_TICKS = 5
) (
    input  logic             clk,
    input  logic             rst,
    flick_check_gen_if.slave bus
);
    localparam int DW = $clog2(DEB_CYCLES) + 1;
    localparam int PW = $clog2(FLICK_MAX + 1) + 1;
    localparam int TW = $clog2(TICK_DIV) + 1;
    localparam int IW = $clog2(PERIOD_TICKS) + 1;

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] FLICK_LIM   = PW'(FLICK_MAX);
    localparam logic [PW-1:0] PRESS_SAT   = PW'(FLICK_MAX + 1);
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [IW-1:0] PERIOD_LAST = IW'(PERIOD_TICKS - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          btn_level_reg;
    logic          level_prev_reg;
    logic [DW-1:0] deb_cnt_reg;
    logic [PW-1:0] press_cnt_reg;
    logic          flick_pend_reg;
    logic          check_reg;
    logic [2:0]    mode_q;
    logic [TW-1:0] pre_cnt_reg;
    logic [IW-1:0] int_cnt_reg;

    logic          deb_hit;
    logic          flick_event;
    logic          mode_change;
    logic          periodic;
    logic          tick;
    logic [TW-1:0] pre_base;
    logic [IW-1:0] int_base;
    logic [TW-1:0] pre_next;
    logic [IW-1:0] int_next;
    logic          check_next;

    assign deb_hit     = (sync2_reg != btn_level_reg) && (deb_cnt_reg == DEB_LAST);
    assign flick_event = level_prev_reg && !btn_level_reg && (press_cnt_reg <= FLICK_LIM);
    assign mode_change = (bus.mode != mode_q);
    assign periodic    = (bus.mode != 3'd0) && (bus.mode <= 3'd5);

    // A mode change restarts the timer as if from reset: the changing edge counts as the first cycle.
    always_comb begin
        pre_base   = mode_change ? '0 : pre_cnt_reg;
        int_base   = mode_change ? '0 : int_cnt_reg;
        tick       = (pre_base == TICK_LAST);
        pre_next   = '0;
        int_next   = '0;
        check_next = 1'b0;
        if (periodic) begin
            pre_next = tick ? '0 : pre_base + 1'b1;
            if (tick)
                int_next = (int_base == PERIOD_LAST) ? '0 : int_base + 1'b1;
            else
                int_next = int_base;
            check_next = tick && (int_base == PERIOD_LAST);
        end else if (bus.mode == 3'd0) begin
            check_next = flick_pend_reg && !check_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg      <= 1'b0;
            sync2_reg      <= 1'b0;
            btn_level_reg  <= 1'b0;
            level_prev_reg <= 1'b0;
            deb_cnt_reg    <= '0;
            press_cnt_reg  <= '0;
            flick_pend_reg <= 1'b0;
            check_reg      <= 1'b0;
            mode_q         <= 3'd0;
            pre_cnt_reg    <= '0;
            int_cnt_reg    <= '0;
        end else begin
            sync1_reg <= bus.btn_raw;
            sync2_reg <= sync1_reg;

            if (sync2_reg != btn_level_reg) begin
                if (deb_hit) begin
                    btn_level_reg <= !btn_level_reg;
                    deb_cnt_reg   <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + 1'b1;
                end
            end else begin
                deb_cnt_reg <= '0;
            end
            level_prev_reg <= btn_level_reg;

            // Counts every cycle the debounced level is high, including the cycle it falls.
            if (deb_hit && !btn_level_reg)
                press_cnt_reg <= '0;
            else if (btn_level_reg && (press_cnt_reg != PRESS_SAT))
                press_cnt_reg <= press_cnt_reg + 1'b1;

            // A new flick beats the clear so it is carried into the next interval.
            if (flick_event)
                flick_pend_reg <= 1'b1;
            else if (check_reg)
                flick_pend_reg <= 1'b0;

            check_reg   <= check_next;
            mode_q      <= bus.mode;
            pre_cnt_reg <= pre_next;
            int_cnt_reg <= int_next;
        end
    end

    assign bus.check     = check_reg;
    assign bus.flick     = flick_pend_reg;
    assign bus.btn_level = btn_level_reg;
endmodule

// File: tb/tb_flick_check_gen.sv
// Directed bench for flick_check_gen: reset, bounce rejection, flick/long-press classification,
// mode-0 and periodic check timing, mode restart, set-wins collision and reset mid-press.
module tb_flick_check_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic lv [0:255];
    logic fl [0:255];
    logic ck [0:255];

    flick_check_gen_if bus ();

    flick_check_gen #(
        .DEB_CYCLES  (4),
        .FLICK_MAX   (20),
        .TICK_DIV    (10),
        .PERIOD_TICKS(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Advance one clock and record outputs just after the edge under index i.
    task automatic step(input int i);
        @(posedge clk);
        #1;
        lv[i] = bus.btn_level;
        fl[i] = bus.flick;
        ck[i] = bus.check;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    function automatic int cnt_lv(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += (lv[i] === 1'b1) ? 1 : 0;
        return n;
    endfunction

    function automatic int cnt_fl(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += (fl[i] === 1'b1) ? 1 : 0;
        return n;
    endfunction

    function automatic int cnt_ck(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += (ck[i] === 1'b1) ? 1 : 0;
        return n;
    endfunction

    // Raw button high for n cycles from the current point, recording total cycles.
    task automatic press(input int n, input int total);
        bus.btn_raw = 1'b1;
        for (int i = 1; i <= total; i++) begin
            step(i);
            if (i == n) bus.btn_raw = 1'b0;
        end
    endtask

    initial begin
        bus.btn_raw = 1'b0;
        bus.mode    = 3'd0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", bus.btn_level, 0);
        chk("rst_flick", bus.flick, 0);
        chk("rst_check", bus.check, 0);
        rst = 1'b0;
        for (int i = 1; i <= 200; i++) step(i);
        chk("idle_level", cnt_lv(1, 200), 0);
        chk("idle_flick", cnt_fl(1, 200), 0);
        chk("idle_check", cnt_ck(1, 200), 0);

        // Bounce rejection: 3-cycle glitches
        for (int r = 0; r < 5; r++) begin
            bus.btn_raw = 1'b1;
            for (int j = 1; j <= 3; j++) step(r * 6 + j);
            bus.btn_raw = 1'b0;
            for (int j = 4; j <= 6; j++) step(r * 6 + j);
        end
        for (int i = 31; i <= 40; i++) step(i);
        chk("bounce_level", cnt_lv(1, 40), 0);
        chk("bounce_flick", cnt_fl(1, 40), 0);

        // Mode-0 flick, 10-cycle press
        press(10, 25);
        chk("f10_lv5", lv[5], 0);
        chk("f10_lv6", lv[6], 1);
        chk("f10_lvcount", cnt_lv(1, 25), 10);
        chk("f10_lv16", lv[16], 0);
        chk("f10_fl16", fl[16], 0);
        chk("f10_fl17", fl[17], 1);
        chk("f10_ck17", ck[17], 0);
        chk("f10_ck18", ck[18], 1);
        chk("f10_fl18", fl[18], 1);
        chk("f10_fl19", fl[19], 0);
        chk("f10_ck19", ck[19], 0);
        chk("f10_ckcount", cnt_ck(1, 25), 1);

        // Boundary: 20 cycles is a flick, 21 is not
        press(20, 35);
        chk("f20_fl27", fl[27], 1);
        chk("f20_ck28", ck[28], 1);
        chk("f20_ckcount", cnt_ck(1, 35), 1);
        press(21, 40);
        chk("f21_lvcount", cnt_lv(1, 40), 21);
        chk("f21_flcount", cnt_fl(1, 40), 0);
        chk("f21_ckcount", cnt_ck(1, 40), 0);

        // Long hold
        press(30, 45);
        chk("long_lvcount", cnt_lv(1, 45), 30);
        chk("long_flcount", cnt_fl(1, 45), 0);
        chk("long_ckcount", cnt_ck(1, 45), 0);

        // Periodic mode 2, mid-interval flick, switch to mode 3
        bus.mode = 3'd2;
        for (int i = 1; i <= 185; i++) begin
            step(i);
            if (i == 55) bus.btn_raw = 1'b1;
            if (i == 65) bus.btn_raw = 1'b0;
            if (i == 130) bus.mode = 3'd3;
        end
        chk("m2_ck49", ck[49], 0);
        chk("m2_ck50", ck[50], 1);
        chk("m2_ck51", ck[51], 0);
        chk("m2_fl71", fl[71], 0);
        chk("m2_fl72", fl[72], 1);
        chk("m2_ck100", ck[100], 1);
        chk("m2_fl100", fl[100], 1);
        chk("m2_fl101", fl[101], 0);
        chk("m3_ck150", ck[150], 0);
        chk("m3_ck180", ck[180], 1);
        chk("m23_ckcount", cnt_ck(1, 185), 3);

        // Mode 4: flick event in the same cycle as check
        bus.mode = 3'd4;
        for (int i = 1; i <= 155; i++) begin
            step(i);
            if (i == 84) bus.btn_raw = 1'b1;
            if (i == 94) bus.btn_raw = 1'b0;
        end
        chk("m4_ck100", ck[100], 1);
        chk("m4_fl100", fl[100], 0);
        chk("m4_fl101", fl[101], 1);
        chk("m4_fl149", fl[149], 1);
        chk("m4_ck150", ck[150], 1);
        chk("m4_fl150", fl[150], 1);
        chk("m4_fl151", fl[151], 0);
        chk("m4_ckcount", cnt_ck(1, 155), 3);

        // Mode 6: flick recorded, no check; then mode 0 consumes it
        bus.mode = 3'd6;
        for (int i = 1; i <= 100; i++) begin
            step(i);
            if (i == 5) bus.btn_raw = 1'b1;
            if (i == 15) bus.btn_raw = 1'b0;
        end
        chk("m6_fl22", fl[22], 1);
        chk("m6_fl100", fl[100], 1);
        chk("m6_ckcount", cnt_ck(1, 100), 0);
        bus.mode = 3'd0;
        step(1);
        step(2);
        chk("m0_ck1", ck[1], 1);
        chk("m0_fl1", fl[1], 1);
        chk("m0_fl2", fl[2], 0);
        chk("m0_ck2", ck[2], 0);

        // Reset mid-press with a pending flick
        bus.mode = 3'd6;
        press(10, 20);
        bus.btn_raw = 1'b1;
        for (int i = 1; i <= 10; i++) step(i);
        chk("mid_lv", lv[10], 1);
        chk("mid_fl", fl[10], 1);
        rst = 1'b1;
        #1;
        chk("arst_level", bus.btn_level, 0);
        chk("arst_flick", bus.flick, 0);
        chk("arst_check", bus.check, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) step(i);
        chk("rel_lv5", lv[5], 0);
        chk("rel_lv6", lv[6], 1);
        bus.btn_raw = 1'b0;
        for (int i = 1; i <= 10; i++) step(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/flick_check_gen.md
# flick_check_gen

Upstream stimulus stage for the mode sequencer. It synchronises and debounces the raw push-button and classifies each press as a flick (short tap) or a long hold. It produces the `flick` level and the `check` strobe that the sequencer samples to advance its 3-bit mode. The `check` period is mode-dependent: in mode 0 `check` fires immediately after a flick; in modes 1–5 it fires on a fixed tick interval.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable synchronised samples required to change the debounced level.
- `FLICK_MAX`, default 20: maximum debounced-high press length, in clk cycles, that counts as a flick.
- `TICK_DIV`, default 10: clk cycles per prescaler tick.
- `PERIOD_TICKS`, default 5: ticks per `check` interval in modes 1–5.
- `clk` input 1: system clock; all state on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `btn_raw` input 1: asynchronous, bouncy push-button, active-high.
- `mode` input 3: current mode fed back from the sequencer (0–5 valid).
- `check` output 1: single-cycle strobe; the sequencer acts on its rising edge.
- `flick` output 1: level; a flick has occurred since the last `check`.
- `btn_level` output 1: debounced button level, for debug and LEDs.

## Operation
- Reset: all registers cleared; `check`=0, `flick`=0, `btn_level`=0; sync flops, counters and `mode_q` are 0.
- Synchroniser: 2-flop chain on `btn_raw`, giving `btn_s`.
- Debounce: counter increments while `btn_s`≠`btn_level` and clears when they are equal.
  - When the count reaches `DEB_CYCLES`, `btn_level` toggles and the counter clears.
  - A glitch shorter than `DEB_CYCLES` cycles never reaches `btn_level`.
- Press measurement: `press_cnt` clears on the `btn_level` rise and increments each cycle while high, saturating at `FLICK_MAX`+1.
- On the `btn_level` fall, a flick event is raised if `press_cnt` ≤ `FLICK_MAX`. A longer press produces no event.
- `flick_pend`, driven onto `flick`:
  - Set on a flick event.
  - Cleared on the edge ending a cycle in which `check`=1.
  - If a flick event and check-clear happen in the same cycle, set wins; the new flick belongs to the next interval.
- Timer: prescaler 0..`TICK_DIV`-1 emits a tick on wrap. The interval counter counts ticks 0..`PERIOD_TICKS`-1.
- `check` generation by `mode`:
  - Mode 0: timer and prescaler held at 0. `check` pulses for 1 cycle when `flick_pend`=1 and `check`=0 the previous cycle, so back-to-back checks are impossible.
  - Modes 1–5: `check` pulses for 1 cycle when the interval counter wraps from `PERIOD_TICKS`-1 on a tick.
  - Modes 6–7: timer held at 0, `check` held at 0, and `flick` is still recorded.
- Mode change: `mode_q` registers `mode`. When `mode`≠`mode_q`, the prescaler and interval counter clear, so each mode gets a full interval. `flick_pend` is unaffected.
- Counter widths are `$clog2` of their terminal value plus 1. There is no arithmetic overflow; all counters wrap or saturate explicitly.

## Timing
- `btn_raw` edge to `btn_level` change: 2 + `DEB_CYCLES` clk edges for a clean edge.
- `btn_level` fall to `flick`=1: 1 cycle.
- Mode 0: `flick` rise to `check` pulse is 1 cycle. `flick` stays high through the `check` cycle and drops the cycle after, so it is stable at the `check` rising edge.
- Modes 1–5: `check` period is exactly `TICK_DIV`×`PERIOD_TICKS` cycles, measured from the mode change or reset release.
- The first `check` comes `TICK_DIV`×`PERIOD_TICKS` cycles after the mode change or reset release.
- `check` and `flick` are registered and glitch-free, as required because the sequencer is edge-sensitive on both.
- `rst` mid-press: all state clears immediately. A press already in progress at release is treated as a new press once `btn_level` rises after debounce.

## Test plan
- Reset/idle: `rst` pulse, `mode`=0, `btn_raw`=0 for 200 cycles -> `check`=0, `flick`=0, `btn_level`=0 throughout.
- Bounce rejection: `btn_raw` toggling with 3-cycle high glitches (`DEB_CYCLES`=4) -> `btn_level` never rises and no `flick`.
- Mode-0 flick: clean 10-cycle press, `mode`=0 -> `btn_level` high 10 cycles; `flick`=1 one cycle after the fall; `check` pulses the next cycle; `flick`=0 the cycle after `check`.
- Long hold: 30-cycle press (`FLICK_MAX`=20) -> no `flick` and no `check` in mode 0.
- Periodic check: `mode`=2 held -> `check` pulses every 50 cycles (`TICK_DIV`=10, `PERIOD_TICKS`=5).
  - A flick in mid-interval keeps `flick`=1 until the next `check`.
  - Switching `mode` to 3 at cycle 30 restarts the interval, so the next `check` is 50 cycles after the switch.
- Simultaneous events: flick event landing in the same cycle as a mode-4 `check` -> `flick` stays 1 after that `check` and is consumed by the following one. Separately, `rst` asserted mid-press -> all outputs 0 immediately.
